ddr2_avl_tester: RTL

Parametrised built-in self-test master for the DDR2 UniPHY controller's Avalon-MM local interface. After calibration completes, it writes a selectable data pattern over a configurable address window in fixed-length bursts. It then reads the window back, compares every beat and reports pass/fail, an error count and the first failing address. It sits between board-level control (start/status) and the controller's avl_* and status ports, and replaces the fixed-counter bring-up stub.

---
 rtl/ddr2_tst_pkg.sv | 23 ++
 rtl/ddr2_pat_gen.sv | 31 +++
 rtl/ddr2_avl_tester.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ddr2_tst_pkg.sv
// Shared encodings for the DDR2 Avalon self-test master: FSM states, pattern
// selects, the 0xA5 fill byte and the error-counter width.
package ddr2_tst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WR_BURST,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE,
        ST_FAIL
    } tst_state_t;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_WALK1    = 2'd1;
    localparam logic [1:0] PAT_XOR_A5   = 2'd2;
    localparam logic [1:0] PAT_INV_ADDR = 2'd3;

    localparam logic [7:0] FILL_BYTE = 8'hA5;
    localparam int         ERR_W     = 16;

endpackage

// File: rtl/ddr2_pat_gen.sv
// Expected/write data for one word: purely combinational, zero latency.
// No flow control; shared by the write path and the read-compare path.
module ddr2_pat_gen
    import ddr2_tst_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 24,
    parameter int IDX_W  = 11
) (
    input  logic [1:0]        pattern_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] walk;

    always_comb begin
        // The size cast zero-extends or truncates the word address to the bus width.
        addr_ext = DATA_W'(addr);
        walk     = DATA_W'(1) << (32'(idx) % 32'(DATA_W));
        case (pattern_sel)
            PAT_WALK1:    data = walk;
            PAT_XOR_A5:   data = addr_ext ^ {(DATA_W/8){FILL_BYTE}};
            PAT_INV_ADDR: data = ~addr_ext;
            default:      data = addr_ext;
        endcase
    end

endmodule

// File: rtl/ddr2_avl_tester.sv
// Write-then-read-back BIST master for the UniPHY Avalon port; first write beat 2 cycles after start.
// Holds command/beat stable while avl_ready=0; aborts after TIMEOUT stall cycles.
module ddr2_avl_tester
    import ddr2_tst_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 24,
    parameter int BURST_W    = 3,
    parameter int BURST_LEN  = 4,
    parameter int START_ADDR = 0,
    parameter int NUM_WORDS  = 1024,
    parameter int TIMEOUT    = 5000
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                start,
    input  logic [1:0]          pattern_sel,
    input  logic                avl_ready,
    output logic                avl_burstbegin,
    output logic [ADDR_W-1:0]   avl_addr,
    input  logic                avl_rdata_valid,
    input  logic [DATA_W-1:0]   avl_rdata,
    output logic [DATA_W-1:0]   avl_wdata,
    output logic [DATA_W/8-1:0] avl_be,
    output logic                avl_read_req,
    output logic                avl_write_req,
    output logic [BURST_W-1:0]  avl_size,
    input  logic                local_init_done,
    input  logic                local_cal_success,
    input  logic                local_cal_fail,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                timeout_err
);

    localparam int                 IDX_W     = $clog2(NUM_WORDS + 1);
    localparam int                 STALL_W   = $clog2(TIMEOUT + 1);
    localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_WORDS - BURST_LEN);

    tst_state_t state, state_nxt;

    logic [ADDR_W-1:0]  burst_addr;
    logic [IDX_W-1:0]   word_idx;
    logic [BURST_W-1:0] beat;
    logic [STALL_W-1:0] stall_cnt;
    logic [1:0]         pat_q;
    logic [ADDR_W-1:0]  cur_addr;
    logic [IDX_W-1:0]   cur_idx;
    logic [DATA_W-1:0]  pat_data;

    logic go, wr_acc, rd_acc, rd_beat, beat_adv;
    logic last_beat, last_burst, stalling, stall_hit;

    assign go         = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
    assign wr_acc     = (state == ST_WR_BURST) && avl_ready;
    assign rd_acc     = (state == ST_RD_CMD) && avl_ready;
    assign rd_beat    = (state == ST_RD_DATA) && avl_rdata_valid;
    assign beat_adv   = wr_acc || rd_beat;
    assign last_beat  = (beat == LAST_BEAT);
    assign last_burst = (word_idx == LAST_IDX);
    assign stalling   = ((state == ST_WR_BURST || state == ST_RD_CMD) && !avl_ready) ||
                        ((state == ST_RD_DATA) && !avl_rdata_valid);
    assign stall_hit  = stalling && (stall_cnt == STALL_W'(TIMEOUT - 1));

    assign cur_addr = burst_addr + ADDR_W'(beat);
    assign cur_idx  = word_idx + IDX_W'(beat);

    ddr2_pat_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_pat_gen (
        .pattern_sel (pat_q),
        .addr        (cur_addr),
        .idx         (cur_idx),
        .data        (pat_data)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        pass           = 1'b0;
        avl_write_req  = 1'b0;
        avl_read_req   = 1'b0;
        avl_burstbegin = 1'b0;
        avl_addr       = '0;
        avl_size       = '0;
        avl_wdata      = '0;
        avl_be         = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_WAIT_CAL;
            end
            ST_WAIT_CAL: begin
                busy = 1'b1;
                if (local_cal_fail)                             state_nxt = ST_FAIL;
                else if (local_init_done && local_cal_success)  state_nxt = ST_WR_BURST;
            end
            ST_WR_BURST: begin
                busy           = 1'b1;
                avl_write_req  = 1'b1;
                avl_burstbegin = (beat == '0);
                avl_addr       = burst_addr;
                avl_size       = BURST_W'(BURST_LEN);
                avl_wdata      = pat_data;
                avl_be         = '1;
                if (stall_hit)                                 state_nxt = ST_FAIL;
                else if (wr_acc && last_beat && last_burst)    state_nxt = ST_RD_CMD;
            end
            ST_RD_CMD: begin
                busy           = 1'b1;
                avl_read_req   = 1'b1;
                avl_burstbegin = 1'b1;
                avl_addr       = burst_addr;
                avl_size       = BURST_W'(BURST_LEN);
                if (stall_hit)   state_nxt = ST_FAIL;
                else if (rd_acc) state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                busy = 1'b1;
                if (stall_hit)                  state_nxt = ST_FAIL;
                else if (rd_beat && last_beat)  state_nxt = last_burst ? ST_DONE : ST_RD_CMD;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
                if (start) state_nxt = ST_WAIT_CAL;
            end
            ST_FAIL: begin
                done = 1'b1;
                if (start) state_nxt = ST_WAIT_CAL;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            burst_addr     <= '0;
            word_idx       <= '0;
            beat           <= '0;
            stall_cnt      <= '0;
            pat_q          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout_err    <= 1'b0;
        end else if (go) begin
            burst_addr     <= ADDR_W'(START_ADDR);
            word_idx       <= '0;
            beat           <= '0;
            stall_cnt      <= '0;
            pat_q          <= pattern_sel;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout_err    <= 1'b0;
        end else begin
            stall_cnt <= stalling ? stall_cnt + STALL_W'(1) : '0;
            if (stall_hit) timeout_err <= 1'b1;

            // err_count saturates, so zero means no mismatch has been seen yet.
            if (rd_beat && (pat_data != avl_rdata)) begin
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                if (err_count == '0) first_err_addr <= cur_addr;
            end

            if (beat_adv) begin
                beat <= last_beat ? '0 : beat + BURST_W'(1);
                if (last_beat && last_burst) begin
                    burst_addr <= ADDR_W'(START_ADDR);
                    word_idx   <= '0;
                end else if (last_beat) begin
                    burst_addr <= burst_addr + ADDR_W'(BURST_LEN);
                    word_idx   <= word_idx + IDX_W'(BURST_LEN);
                end
            end
        end
    end

endmodule
